// File: rtl/debounce_channel.sv
// One debounced button channel: two-flop synchronizer, stability counter,
// registered level plus single-cycle press/release pulses.
module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int COUNT_WIDTH     = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic button_raw,
    output logic button_level,
    output logic button_pressed,
    output logic button_released
);

    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                   sync1;
    logic                   sync2;
    logic [COUNT_WIDTH-1:0] count;

    // The count saturates at LAST_COUNT: reaching it commits the new level,
    // so the counter can never wrap. Any agreeing sample restarts the run.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1           <= 1'b0;
            sync2           <= 1'b0;
            count           <= '0;
            button_level    <= 1'b0;
            button_pressed  <= 1'b0;
            button_released <= 1'b0;
        end else begin
            sync1           <= button_raw;
            sync2           <= sync1;
            button_pressed  <= 1'b0;
            button_released <= 1'b0;
            if (sync2 != button_level) begin
                if (count == LAST_COUNT) begin
                    button_level    <= sync2;
                    count           <= '0;
                    button_pressed  <= sync2;
                    button_released <= ~sync2;
                end else begin
                    count <= count + 1'b1;
                end
            end else begin
                count <= '0;
            end
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel button debouncer between the board's button pads and the
// core's reset/halt inputs; each channel is debounced independently.
module button_debouncer #(
    parameter int CLOCK_FREQUENCY  = 50000000,
    parameter int DEBOUNCE_TIME_US = 10000,
    parameter int CHANNELS         = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] button_raw,
    output logic [CHANNELS-1:0] button_level,
    output logic [CHANNELS-1:0] button_pressed,
    output logic [CHANNELS-1:0] button_released
);

    // Stable time in clock cycles, never less than one cycle.
    localparam int DEBOUNCE_PRODUCT = (CLOCK_FREQUENCY / 1000000) * DEBOUNCE_TIME_US;
    localparam int DEBOUNCE_CYCLES  = (DEBOUNCE_PRODUCT < 1) ? 1 : DEBOUNCE_PRODUCT;
    localparam int COUNT_WIDTH      = $clog2(DEBOUNCE_CYCLES + 1);

    genvar ch;
    generate
        for (ch = 0; ch < CHANNELS; ch++) begin : g_channel
            debounce_channel #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .COUNT_WIDTH    (COUNT_WIDTH)
            ) u_channel (
                .clock          (clock),
                .reset_n        (reset_n),
                .button_raw     (button_raw[ch]),
                .button_level   (button_level[ch]),
                .button_pressed (button_pressed[ch]),
                .button_released(button_released[ch])
            );
        end
    endgenerate

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed scenarios with hand-computed edge
// timing plus long randomized bouncing checked against a window model.
module tb_button_debouncer;

    localparam int CLOCK_FREQUENCY  = 1000000;
    localparam int DEBOUNCE_TIME_US = 8;
    localparam int CH               = 2;
    localparam int DC               = (CLOCK_FREQUENCY / 1000000) * DEBOUNCE_TIME_US;

    logic          clock;
    logic          reset_n;
    logic [CH-1:0] button_raw;
    logic [CH-1:0] button_level;
    logic [CH-1:0] button_pressed;
    logic [CH-1:0] button_released;

    int errors = 0;
    int checks = 0;
    int press_cnt [CH];
    int rel_cnt   [CH];

    logic [3*CH-1:0] exp_q[$];

    button_debouncer #(
        .CLOCK_FREQUENCY (CLOCK_FREQUENCY),
        .DEBOUNCE_TIME_US(DEBOUNCE_TIME_US),
        .CHANNELS        (CH)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .button_raw     (button_raw),
        .button_level   (button_level),
        .button_pressed (button_pressed),
        .button_released(button_released)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The input reaches the decision logic two samples late. The level moves
    // to v once the last DC delayed samples are all v and differ from the level.
    logic [1:0]    m_dly  [CH];
    logic [DC-1:0] m_win  [CH];
    int            m_fill [CH];
    logic [CH-1:0] m_level, m_pressed, m_released;

    task automatic clear_model();
        for (int c = 0; c < CH; c++) begin
            m_dly[c]  = '0;
            m_win[c]  = '0;
            m_fill[c] = 0;
        end
        m_level    = '0;
        m_pressed  = '0;
        m_released = '0;
    endtask

    always @(negedge reset_n) begin
        clear_model();
        exp_q.delete();
    end

    always @(posedge clock) begin
        if (!reset_n) begin
            clear_model();
        end else begin
            for (int c = 0; c < CH; c++) begin
                logic del;
                del          = m_dly[c][1];
                m_dly[c]     = {m_dly[c][0], button_raw[c]};
                m_win[c]     = {m_win[c][DC-2:0], del};
                if (m_fill[c] < DC) m_fill[c]++;
                m_pressed[c]  = 1'b0;
                m_released[c] = 1'b0;
                if (m_fill[c] == DC) begin
                    if (m_win[c] == {DC{1'b1}} && !m_level[c]) begin
                        m_level[c]   = 1'b1;
                        m_pressed[c] = 1'b1;
                    end else if (m_win[c] == {DC{1'b0}} && m_level[c]) begin
                        m_level[c]    = 1'b0;
                        m_released[c] = 1'b1;
                    end
                end
            end
        end
        exp_q.push_back({m_level, m_pressed, m_released});
    end

    // ---------------- scoreboard compare ----------------
    initial begin
        logic [3*CH-1:0] exp_v;
        for (int c = 0; c < CH; c++) begin
            press_cnt[c] = 0;
            rel_cnt[c]   = 0;
        end
        forever begin
            @(posedge clock);
            #3;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL model_queue: got empty queue expected one entry at %0t", $time);
            end else begin
                exp_v = exp_q.pop_front();
                check("model", 8'({button_level, button_pressed, button_released}), 8'(exp_v));
            end
            for (int c = 0; c < CH; c++) begin
                if (button_pressed[c])  press_cnt[c]++;
                if (button_released[c]) rel_cnt[c]++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Assumes the caller sits on a falling edge; v is sampled on n rising edges.
    task automatic hold_ch0(input logic v, input int n);
        button_raw[0] = v;
        repeat (n) @(negedge clock);
    endtask

    task automatic after_edges(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int p0, r0;
        int run_left [CH];
        int rst_at;

        reset_n    = 1'b0;
        button_raw = 2'b11;
        after_edges(3);
        check("reset_hold_outputs", 8'({button_level, button_pressed, button_released}), 8'h00);

        // Buttons held through reset release: level at edge 10 after release.
        @(negedge clock);
        reset_n = 1'b1;
        after_edges(9);
        check("rst_release_level_e9", 8'(button_level), 8'h00);
        after_edges(1);
        check("rst_release_level_e10", 8'(button_level), 8'h03);
        check("rst_release_pressed_e10", 8'(button_pressed), 8'h03);
        after_edges(1);
        check("rst_release_pressed_e11", 8'(button_pressed), 8'h00);
        check("rst_release_level_e11", 8'(button_level), 8'h03);

        @(negedge clock);
        button_raw = 2'b00;
        after_edges(15);
        check("both_released_level", 8'(button_level), 8'h00);

        // Clean step on channel 0 sampled at edge 0.
        @(negedge clock);
        button_raw[0] = 1'b1;
        after_edges(9);
        check("step_level_e8", 8'(button_level), 8'h00);
        after_edges(1);
        check("step_level_e9", 8'(button_level), 8'h01);
        check("step_pressed_e9", 8'(button_pressed), 8'h01);
        after_edges(1);
        check("step_pressed_e10", 8'(button_pressed), 8'h00);

        @(negedge clock);
        hold_ch0(1'b0, 15);
        check("step_return_level", 8'(button_level), 8'h00);

        // Bounce rejection: 1x5, 0x2, 1x7, then 0.
        p0 = press_cnt[0];
        r0 = rel_cnt[0];
        hold_ch0(1'b1, 5);
        hold_ch0(1'b0, 2);
        hold_ch0(1'b1, 7);
        hold_ch0(1'b0, 20);
        check("bounce_level", 8'(button_level), 8'h00);
        check("bounce_no_press", 8'(press_cnt[0] - p0), 8'h00);
        check("bounce_no_release", 8'(rel_cnt[0] - r0), 8'h00);

        // Bounce three times, then settle high.
        p0 = press_cnt[0];
        for (int i = 0; i < 3; i++) begin
            hold_ch0(1'b1, 3);
            hold_ch0(1'b0, 2);
        end
        button_raw[0] = 1'b1;
        after_edges(9);
        check("settle_pressed_e8", 8'(button_pressed), 8'h00);
        after_edges(1);
        check("settle_pressed_e9", 8'(button_pressed), 8'h01);
        check("settle_level_e9", 8'(button_level), 8'h01);
        after_edges(5);
        check("settle_single_press", 8'(press_cnt[0] - p0), 8'h01);

        // Release, then reset mid-count: no release pulse may appear.
        r0 = rel_cnt[0];
        @(negedge clock);
        button_raw[0] = 1'b0;
        repeat (4) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("midcount_reset_outputs", 8'({button_level, button_pressed, button_released}), 8'h00);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        after_edges(20);
        check("midcount_no_release", 8'(rel_cnt[0] - r0), 8'h00);
        check("midcount_level", 8'(button_level), 8'h00);

        // Randomized bouncing on both channels with one reset in the middle.
        for (int c = 0; c < CH; c++) run_left[c] = $urandom_range(1, 14);
        rst_at = $urandom_range(800, 2000);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            for (int c = 0; c < CH; c++) begin
                run_left[c]--;
                if (run_left[c] == 0) begin
                    button_raw[c] = ~button_raw[c];
                    run_left[c]   = $urandom_range(1, 14);
                end
            end
            if (i == rst_at)     reset_n = 1'b0;
            if (i == rst_at + 3) reset_n = 1'b1;
        end

        @(negedge clock);
        button_raw = 2'b00;
        after_edges(20);
        check("final_level", 8'(button_level), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
